// File: rtl/mic_pkg.sv
// Shared definitions for the microphone conditioning path: state encoding
// and the counter width helper.
package mic_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_QUALIFY = 3'd1;
    localparam logic [2:0] ENC_HOLD    = 3'd2;
    localparam logic [2:0] ENC_LOCKOUT = 3'd3;
    localparam logic [2:0] ENC_ARMED   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_QUALIFY = ENC_QUALIFY,
        ST_HOLD    = ENC_HOLD,
        ST_LOCKOUT = ENC_LOCKOUT,
        ST_ARMED   = ENC_ARMED
    } state_t;

    // One shared counter serves every timed state, so it is sized for the
    // longest interval plus one spare bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mic_sync.sv
// Polarity correction followed by a SYNC_STAGES-deep synchronizer chain.
// The chain holds corrected values, so clearing it to 0 means "inactive".
module mic_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic s
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level;

    assign level = ACTIVE_HIGH ? raw : ~raw;
    assign s     = chain[SYNC_STAGES-1];

    // Shift the corrected input through the chain; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) chain <= '0;
        else      chain <= {chain[SYNC_STAGES-2:0], level};
    end

endmodule

// File: rtl/mic_conditioner.sv
// Microphone front end: synchronize, debounce, stretch and lock out so each
// accepted sound gives exactly one clean mic_level pulse downstream.
// Optional double-clap mode: define MIC_DOUBLE_CLAP_EN.
//
// state   | meaning
// IDLE    | waiting for an active synchronized input while enabled
// QUALIFY | input must stay active DEBOUNCE_CYCLES to be accepted
// HOLD    | mic_level high for HOLD_CYCLES, input ignored
// LOCKOUT | dead time; leaves only after LOCKOUT_CYCLES and input inactive
// ARMED   | (double clap) first clap seen, waiting for second within window
import mic_pkg::*;

module mic_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int LOCKOUT_CYCLES  = 25000000,
    parameter bit ACTIVE_HIGH     = 1'b1,
    parameter int WINDOW_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mic_raw,
    input  logic       enable,
    output logic       mic_level,
    output logic       mic_pulse,
    output logic       busy,
    output logic [7:0] event_count
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, LOCKOUT_CYCLES, WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic             s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulse_next, level_next, busy_next, accept;
    logic [7:0]       count_next;

`ifdef MIC_DOUBLE_CLAP_EN
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    logic [CNT_W-1:0] wcnt, wcnt_next;
    logic             second, second_next;
    logic             released, released_next;
`endif

    mic_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .raw (mic_raw),
        .s   (s)
    );

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mic_level   <= 1'b0;
            mic_pulse   <= 1'b0;
            busy        <= 1'b0;
            event_count <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mic_level   <= level_next;
            mic_pulse   <= pulse_next;
            busy        <= busy_next;
            event_count <= count_next;
        end
    end

`ifdef MIC_DOUBLE_CLAP_EN
    // Double-clap window counter and pass-tracking flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt     <= '0;
            second   <= 1'b0;
            released <= 1'b0;
        end else begin
            wcnt     <= wcnt_next;
            second   <= second_next;
            released <= released_next;
        end
    end
`endif

    // Next-state, counter and output decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        count_next = event_count;
        accept     = 1'b0;
`ifdef MIC_DOUBLE_CLAP_EN
        wcnt_next     = wcnt;
        second_next   = second;
        released_next = released;
`endif
        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state_next = ST_QUALIFY;
                        cnt_next   = '0;
                    end
                end
                ST_QUALIFY: begin
`ifdef MIC_DOUBLE_CLAP_EN
                    if (second) wcnt_next = wcnt + 1'b1;
`endif
                    if (!s) begin
`ifdef MIC_DOUBLE_CLAP_EN
                        state_next = second ? ST_ARMED : ST_IDLE;
`else
                        state_next = ST_IDLE;
`endif
                        cnt_next = '0;
                    end else if (cnt == DB_LAST) begin
                        cnt_next = '0;
`ifdef MIC_DOUBLE_CLAP_EN
                        if (second) begin
                            accept = 1'b1;
                        end else begin
                            state_next    = ST_ARMED;
                            wcnt_next     = '0;
                            second_next   = 1'b1;
                            released_next = 1'b0;
                        end
`else
                        accept = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
`ifdef MIC_DOUBLE_CLAP_EN
                    // A completed second qualification wins over the window edge.
                    if (second && !accept && wcnt == WIN_LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
`endif
                end
                ST_HOLD: begin
                    if (cnt == HO_LAST) begin
                        state_next = ST_LOCKOUT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    // Counter parks at its terminal value while the sound persists.
                    if (cnt != LO_LAST) begin
                        cnt_next = cnt + 1'b1;
                    end else if (!s) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
`ifdef MIC_DOUBLE_CLAP_EN
                ST_ARMED: begin
                    wcnt_next = wcnt + 1'b1;
                    if (wcnt == WIN_LAST) begin
                        state_next = ST_IDLE;
                    end else if (!s) begin
                        released_next = 1'b1;
                    end else if (released) begin
                        state_next = ST_QUALIFY;
                        cnt_next   = '0;
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        if (accept) begin
            state_next = ST_HOLD;
            pulse_next = 1'b1;
            if (event_count != 8'hFF) count_next = event_count + 8'd1;
        end

`ifdef MIC_DOUBLE_CLAP_EN
        if (state_next == ST_IDLE) begin
            wcnt_next     = '0;
            second_next   = 1'b0;
            released_next = 1'b0;
        end
`endif
        level_next = (state_next == ST_HOLD);
        busy_next  = (state_next != ST_IDLE);
    end

endmodule
